// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequencer for one corelet tile pass.
//   Loads col weight words xmem -> L0 -> mac_array, streams len activation
//   vectors through L0 into the array, then drains ofifo rows into pmem.
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   start                1-cycle pulse, accepted only in IDLE
//   acc_mode             latched at start, drives inst[33] on pmem writes
//   w_base/x_base/p_base xmem weight, xmem activation, pmem output bases
//   len                  activation vectors per pass (0 = no-op)
//   L0_full, ofifo_valid corelet status flags
//   inst                 34-bit corelet/SRAM command bus
//   busy, done           pass in progress / 1-cycle completion pulse
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               acc_mode,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic [len_bw-1:0]  len,
  input  logic               L0_full,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               busy,
  output logic               done
);

  localparam int CW = (len_bw > $clog2(col + row)) ? len_bw + 1 : $clog2(col + row) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_W_L0, S_W_ARR, S_X_L0, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      rd_cnt;   // xmem reads issued
  logic [CW-1:0]      wr_cnt;   // L0 writes landed
  logic [CW-1:0]      ex_cnt;   // W_ARR cycle / execute count / drain count
  logic [CW-1:0]      wr_next;
  logic [CW-1:0]      len_q;
  logic [addr_bw-1:0] w_base_q, x_base_q, p_base_q;
  logic               acc_mode_q;

  logic               acc_q, cen_p_q, cen_x_q;
  logic [addr_bw-1:0] a_p_q, a_x_q;
  logic               ofifo_rd_q, l0_rd_q, l0_wr_q, exec_q, load_q;

  // WEN_xmem is tied high and WEN_pmem low (only gated by CEN_pmem), so the
  // idle word is 34'h1_000C_0000.
  assign inst = {acc_q, cen_p_q, 1'b0, a_p_q, cen_x_q, 1'b1, a_x_q,
                 ofifo_rd_q, 2'b00, l0_rd_q, l0_wr_q, exec_q, load_q};

  // Counts the L0 write landing on this edge as already present.
  assign wr_next = wr_cnt + CW'(l0_wr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      ex_cnt     <= '0;
      len_q      <= '0;
      w_base_q   <= '0;
      x_base_q   <= '0;
      p_base_q   <= '0;
      acc_mode_q <= 1'b0;
      acc_q      <= 1'b0;
      cen_p_q    <= 1'b1;
      a_p_q      <= '0;
      cen_x_q    <= 1'b1;
      a_x_q      <= '0;
      ofifo_rd_q <= 1'b0;
      l0_rd_q    <= 1'b0;
      l0_wr_q    <= 1'b0;
      exec_q     <= 1'b0;
      load_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cen_x_q    <= 1'b1;
      l0_rd_q    <= 1'b0;
      load_q     <= 1'b0;
      exec_q     <= 1'b0;
      ofifo_rd_q <= 1'b0;
      cen_p_q    <= 1'b1;
      acc_q      <= 1'b0;
      done       <= 1'b0;
      l0_wr_q    <= ~cen_x_q;   // SRAM data is valid one cycle after the read
      busy       <= (state != S_IDLE);

      case (state)
        S_IDLE: begin
          a_x_q  <= '0;
          a_p_q  <= '0;
          rd_cnt <= '0;
          wr_cnt <= '0;
          ex_cnt <= '0;
          if (start) begin
            w_base_q   <= w_base;
            x_base_q   <= x_base;
            p_base_q   <= p_base;
            len_q      <= CW'(len);
            acc_mode_q <= acc_mode;
            state      <= (len != '0) ? S_W_L0 : S_DONE;
          end
        end

        S_W_L0: begin
          if (rd_cnt < CW'(col) && !L0_full) begin
            cen_x_q <= 1'b0;
            a_x_q   <= w_base_q + addr_bw'(rd_cnt);
            rd_cnt  <= rd_cnt + CW'(1);
          end
          wr_cnt <= wr_next;
          if (wr_next == CW'(col)) begin
            state  <= S_W_ARR;
            ex_cnt <= '0;
          end
        end

        S_W_ARR: begin
          if (ex_cnt < CW'(col)) begin
            l0_rd_q <= 1'b1;
            load_q  <= 1'b1;
          end
          ex_cnt <= ex_cnt + CW'(1);
          if (ex_cnt == CW'(col + row - 1)) begin
            state  <= S_X_L0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            ex_cnt <= '0;
          end
        end

        // Activation reads keep running in EXEC until all len are issued.
        S_X_L0, S_EXEC: begin
          if (rd_cnt < len_q && !L0_full) begin
            cen_x_q <= 1'b0;
            a_x_q   <= x_base_q + addr_bw'(rd_cnt);
            rd_cnt  <= rd_cnt + CW'(1);
          end
          wr_cnt <= wr_next;
          if (state == S_X_L0) begin
            if (wr_next != '0) state <= S_EXEC;
          end else begin
            if (ex_cnt < len_q && wr_next > ex_cnt) begin
              l0_rd_q <= 1'b1;
              exec_q  <= 1'b1;
              ex_cnt  <= ex_cnt + CW'(1);
            end
            if (ex_cnt == len_q) begin
              state  <= S_DRAIN;
              ex_cnt <= '0;
            end
          end
        end

        // A read just issued has not yet cleared ofifo_valid, so back-to-back
        // reads are suppressed to avoid popping a row twice.
        S_DRAIN: begin
          if (ofifo_valid && !ofifo_rd_q) begin
            ofifo_rd_q <= 1'b1;
            cen_p_q    <= 1'b0;
            acc_q      <= acc_mode_q;
            a_p_q      <= p_base_q + addr_bw'(ex_cnt);
            ex_cnt     <= ex_cnt + CW'(1);
            if (ex_cnt == len_q - CW'(1)) state <= S_DONE;
          end
        end

        S_DONE: begin
          a_x_q <= '0;
          a_p_q <= '0;
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
module tb_corelet_ctrl;

  localparam logic [33:0] IDLE_INST = 34'h1_000C_0000;

  logic        clk = 1'b0;
  logic        reset, start, acc_mode, L0_full, ofifo_valid;
  logic [10:0] w_base, x_base, p_base;
  logic [7:0]  len;
  logic [33:0] inst;
  logic        busy, done;

  int n_chk = 0;
  int n_fail = 0;

  logic [10:0] xa[$];
  logic [10:0] pa[$];
  int load_cnt, exec_cnt, both_cnt, l0_mis, l0wr_cnt, stall_cnt, stall_viol;
  int rd_viol, acc_mis, acc_cnt, busy_cnt, done_c, last_wr_c;
  bit timeout;

  corelet_ctrl #(.row(8), .col(8), .addr_bw(11), .len_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .len(len),
    .L0_full(L0_full), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // xmem address list: n1 words from b1, then n2 words from b2 (mod 2048)
  task automatic check_xa(input string tag, input int b1, input int n1, input int b2, input int n2);
    check({tag, "_xa_n"}, 64'(xa.size()), 64'(n1 + n2));
    for (int i = 0; i < n1 + n2; i++) begin
      int e;
      e = (i < n1) ? (b1 + i) % 2048 : (b2 + i - n1) % 2048;
      check($sformatf("%s_xa%0d", tag, i), (i < xa.size()) ? 64'(xa[i]) : 64'hDEAD, 64'(e));
    end
  endtask

  task automatic check_pa(input string tag, input int b, input int n);
    check({tag, "_pa_n"}, 64'(pa.size()), 64'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pa%0d", tag, i), (i < pa.size()) ? 64'(pa[i]) : 64'hDEAD, 64'((b + i) % 2048));
  endtask

  // Pulse start, then observe one cycle per iteration until done (bounded).
  task automatic run_pass(input int stall_lo, input bit toggle_valid, input int restart_c);
    logic [10:0] prev_ax;
    logic        prev_cen_low;
    xa.delete(); pa.delete();
    load_cnt = 0; exec_cnt = 0; both_cnt = 0; l0_mis = 0; l0wr_cnt = 0;
    stall_cnt = 0; stall_viol = 0; rd_viol = 0; acc_mis = 0; acc_cnt = 0;
    busy_cnt = 0; done_c = -1; last_wr_c = -1; timeout = 1'b1;
    prev_ax = '0; prev_cen_low = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      L0_full     = (c >= stall_lo && c < stall_lo + 3);
      ofifo_valid = toggle_valid ? (c % 2 == 0) : 1'b1;
      start       = (c == restart_c);
      if (c == restart_c) len = len + 8'd1;
      tick();
      if (!inst[19]) xa.push_back(inst[17:7]);
      if (L0_full) begin
        stall_cnt++;
        if (!inst[19] || inst[17:7] !== prev_ax) stall_viol++;
      end
      if (inst[2] !== prev_cen_low) l0_mis++;
      if (inst[2]) l0wr_cnt++;
      if (inst[0]) load_cnt++;
      if (inst[1]) exec_cnt++;
      if (inst[0] && inst[1]) both_cnt++;
      if (!inst[32]) begin
        pa.push_back(inst[30:20]);
        last_wr_c = c;
      end
      if (inst[6] && !ofifo_valid) rd_viol++;
      if (inst[6] !== !inst[32]) rd_viol++;
      if (inst[33] !== (!inst[32] && acc_mode)) acc_mis++;
      if (inst[33]) acc_cnt++;
      if (busy) busy_cnt++;
      prev_ax = inst[17:7];
      prev_cen_low = !inst[19];
      if (done) begin
        done_c = c;
        timeout = 1'b0;
        break;
      end
    end
    start = 1'b0; L0_full = 1'b0; ofifo_valid = 1'b0;
  endtask

  task automatic post_checks(input string tag);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_busy_span"}, 64'(busy_cnt), 64'(done_c + 1));
    check({tag, "_l0wr_align"}, 64'(l0_mis), 64'd0);
    check({tag, "_load_exec_overlap"}, 64'(both_cnt), 64'd0);
    tick();
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_after"}, 64'(done), 64'd0);
    check({tag, "_inst_idle"}, 64'(inst), 64'(IDLE_INST));
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; acc_mode = 1'b0; L0_full = 1'b0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; p_base = '0; len = '0;
    repeat (2) tick();
    check("reset_inst", 64'(inst), 64'(IDLE_INST));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    // Basic pass: weights 0..7, activations 16..19
    w_base = 11'd0; x_base = 11'd16; p_base = 11'd100; len = 8'd4; acc_mode = 1'b0;
    run_pass(1000, 1'b0, -1);
    check_xa("basic", 0, 8, 16, 4);
    check("basic_load", 64'(load_cnt), 64'd8);
    check("basic_exec", 64'(exec_cnt), 64'd4);
    check("basic_l0wr", 64'(l0wr_cnt), 64'd12);
    check_pa("basic", 100, 4);
    check("basic_ofifo_rd", 64'(rd_viol), 64'd0);
    post_checks("basic");

    // L0_full for 3 cycles during weight reads
    w_base = 11'd0; x_base = 11'd16; p_base = 11'd100; len = 8'd4;
    run_pass(2, 1'b0, -1);
    check("stall_cycles", 64'(stall_cnt), 64'd3);
    check("stall_hold", 64'(stall_viol), 64'd0);
    check_xa("stall", 0, 8, 16, 4);
    check("stall_l0wr", 64'(l0wr_cnt), 64'd12);
    check("stall_load", 64'(load_cnt), 64'd8);
    post_checks("stall");

    // Drain with pmem address wrap and toggling ofifo_valid
    w_base = 11'd3; x_base = 11'd50; p_base = 11'd2040; len = 8'd10;
    run_pass(1000, 1'b1, -1);
    check_pa("drain", 2040, 10);
    check("drain_ofifo_rd", 64'(rd_viol), 64'd0);
    check("drain_done_lat", 64'(done_c), 64'(last_wr_c + 1));
    check("drain_exec", 64'(exec_cnt), 64'd10);
    check("drain_acc", 64'(acc_cnt), 64'd0);
    post_checks("drain");

    // len = 0: no-op pass
    len = 8'd0;
    run_pass(1000, 1'b0, -1);
    check("noop_xmem", 64'(xa.size()), 64'd0);
    check("noop_pmem", 64'(pa.size()), 64'd0);
    check("noop_done_cycle", 64'(done_c), 64'd0);
    check("noop_busy", 64'(busy_cnt), 64'd1);
    check("noop_load", 64'(load_cnt), 64'd0);
    post_checks("noop");

    // acc_mode=1 plus an extra start while busy
    w_base = 11'd8; x_base = 11'd40; p_base = 11'd500; len = 8'd3; acc_mode = 1'b1;
    run_pass(1000, 1'b0, 5);
    check("acc_count", 64'(acc_cnt), 64'd3);
    check("acc_only_on_write", 64'(acc_mis), 64'd0);
    check("acc_exec", 64'(exec_cnt), 64'd3);
    check_pa("acc", 500, 3);
    check_xa("acc", 8, 8, 40, 3);
    post_checks("acc");
    repeat (4) tick();
    check("restart_ignored_busy", 64'(busy), 64'd0);
    acc_mode = 1'b0;

    // Reset in the middle of EXEC, then a clean pass with xmem wrap
    w_base = 11'd0; x_base = 11'd0; p_base = 11'd0; len = 8'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      tick();
      if (inst[1]) seen = 1'b1;
    end
    check("rst_reach_exec", 64'(seen), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_inst", 64'(inst), 64'(IDLE_INST));
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_stays_idle", 64'(inst), 64'(IDLE_INST));
    w_base = 11'd2045; x_base = 11'd30; p_base = 11'd7; len = 8'd2;
    run_pass(1000, 1'b0, -1);
    check_xa("clean", 2045, 8, 30, 2);
    check("clean_load", 64'(load_cnt), 64'd8);
    check("clean_exec", 64'(exec_cnt), 64'd2);
    check_pa("clean", 7, 2);
    post_checks("clean");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
